// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver, LSB first, with a one-entry valid/ready
// output buffer. The serial input is synchronized with two flops and every
// decision is made on the synchronized line (rxs).
//
// Optional feature macro: UART_RX_PARITY_EN
//   Defined: an even-parity bit is expected between data bit 7 and the stop
//            bit. A mismatch pulses parity_err_o and drops the byte.
//   Undefined: plain 8N1 framing, and parity_err_o is tied to 0.
//
// Ports:
//   clk_i        system clock
//   rst_i        synchronous reset, active-high
//   rx_i         asynchronous serial line, idle high
//   data_o       received byte, stable while valid_o is high
//   valid_o      byte available
//   ready_i      consumer accepts the byte when valid_o & ready_i
//   frame_err_o  1-cycle pulse: stop bit sampled low
//   overrun_o    1-cycle pulse: byte completed while the buffer was full
//   parity_err_o 1-cycle pulse: even-parity mismatch
//
// FSM states:
//   state    | meaning
//   S_IDLE   | line idle, waiting for rxs to go low
//   S_START  | timing to the middle of the start bit to confirm it
//   S_DATA   | sampling the 8 data bits, one per bit period
//   S_PARITY | sampling the parity bit (parity build only)
//   S_STOP   | sampling the stop bit, then deliver or flag a framing error
//   S_BREAK  | line held low after a bad stop bit, waiting for it to rise

module uart_rx #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rx_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rxs;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shreg;
  logic            cnt_clr;
  logic            bit_clr;
  logic            shift_en;
  logic            stop_tick;
  logic            par_ok;
  logic            deliver;

`ifdef UART_RX_PARITY_EN
  logic            par_bit;
  logic            par_cap;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx_i;
      rxs     <= rx_meta;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    bit_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_tick = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_cap   = 1'b0;
`endif
    case (state)
      S_IDLE: begin
        cnt_clr = 1'b1;
        if (!rxs) state_nxt = S_START;
      end
      S_START: begin
        if (cnt == HALF_M1) begin
          cnt_clr = 1'b1;
          if (!rxs) begin
            bit_clr   = 1'b1;
            state_nxt = S_DATA;
          end else begin
            // line went back high before mid start bit: treat as glitch
            state_nxt = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (cnt == FULL_M1) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = S_PARITY;
`else
            state_nxt = S_STOP;
`endif
          end
        end
      end
      S_PARITY: begin
        if (cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
`ifdef UART_RX_PARITY_EN
          par_cap   = 1'b1;
`endif
          state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (cnt == FULL_M1) begin
          cnt_clr   = 1'b1;
          stop_tick = 1'b1;
          state_nxt = rxs ? S_IDLE : S_BREAK;
        end
      end
      S_BREAK: begin
        cnt_clr = 1'b1;
        if (rxs) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_RX_PARITY_EN
  // even parity: data bits plus parity bit must XOR to zero
  assign par_ok = ~(^{shreg, par_bit});
`else
  assign par_ok = 1'b1;
`endif

  assign deliver = stop_tick & rxs & par_ok;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt     <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (bit_clr) begin
        bit_idx <= '0;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 3'd1;
      end
      // shift in from the MSB so the first (LSB) bit ends up in bit 0
      if (shift_en) shreg <= {rxs, shreg[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      par_bit      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      if (par_cap) par_bit <= rxs;
      // flagged even when the stop bit also fails, so both pulses coincide
      parity_err_o <= stop_tick & ~par_ok;
    end
  end
`else
  assign parity_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_o      <= 8'h00;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      frame_err_o <= stop_tick & ~rxs;
      overrun_o   <= deliver & valid_o & ~ready_i;
      // a byte accepted this cycle frees the slot for the new byte
      if (deliver && (!valid_o || ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule
